// File: rtl/accel_mem_arbiter_pkg.sv
// Shared types for the banked memory arbiter: arbitration policy, requester identity
// and the bank-select width helper.
package accel_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_PRIO    = 2'd0,
        ACC_PRIO    = 2'd1,
        ROUND_ROBIN = 2'd2
    } arb_mode_t;

    typedef enum logic {
        REQ_BUS = 1'b0,
        REQ_ACC = 1'b1
    } requester_t;

    function automatic int bank_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

endpackage

// File: rtl/accel_mem_arbiter_if.sv
// Requester port of the arbiter: request fields, same-cycle grant and the
// one-cycle-later response.
interface accel_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/accel_mem_arbiter_bank_arb.sv
// Per-bank conflict resolver. Holds the round-robin history (last conflict winner)
// for its bank.
module accel_bank_arb
    import accel_mem_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_bus_hit,
    input  logic      i_acc_hit,
    input  arb_mode_t i_mode,
    input  logic      i_wait_exp,
    output logic      o_bus_win,
    output logic      o_acc_win
);
    requester_t r_rr_last;
    logic       w_conflict;
    logic       w_bus_first;

    always_comb begin
        w_conflict  = i_bus_hit && i_acc_hit;
        w_bus_first = 1'b0;
        case (i_mode)
            BUS_PRIO:    w_bus_first = 1'b1;
            ROUND_ROBIN: w_bus_first = (r_rr_last == REQ_ACC);
            default:     w_bus_first = i_wait_exp;
        endcase
        o_bus_win = i_bus_hit && (!w_conflict || w_bus_first);
        o_acc_win = i_acc_hit && (!w_conflict || !w_bus_first);
    end

    // History tracks every conflict so the first RR conflict after reset goes to the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= REQ_ACC;
        end else if (w_conflict) begin
            r_rr_last <= w_bus_first ? REQ_BUS : REQ_ACC;
        end
    end
endmodule

// File: rtl/accel_mem_arbiter.sv
// Word-interleaved multi-bank front end shared by the peripheral bus and the accelerator,
// with selectable conflict policy, bus starvation guard, lock mode and conflict statistics.
module accel_mem_arbiter
    import accel_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int MAX_WAIT   = 4,
    localparam int BANK_BITS = bank_bits(NUM_BANKS),
    localparam int BANK_AW   = ADDR_WIDTH - BANK_BITS,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  arb_mode_t                     i_mode,
    input  logic                          i_lock,
    input  logic                          i_conf_clr,
    accel_mem_arbiter_if.slave            bus,
    accel_mem_arbiter_if.slave            acc,
    output logic [NUM_BANKS-1:0]          o_ram_en,
    output logic [NUM_BANKS-1:0]          o_ram_we,
    output logic [NUM_BANKS*BANK_AW-1:0]  o_ram_addr,
    output logic [NUM_BANKS*BE_W-1:0]     o_ram_be,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_ram_rdata,
    output logic [15:0]                   o_conflict_cnt
);
    localparam int BSEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [BSEL_W-1:0]   w_bus_bank, w_acc_bank;
    logic [BANK_AW-1:0]  w_bus_row, w_acc_row;
    logic [NUM_BANKS-1:0] w_bus_hit, w_acc_hit, w_bus_win, w_acc_win;
    logic                w_wait_exp;
    logic                w_conflict;
    logic [DATA_WIDTH-1:0] w_ram_rdata [NUM_BANKS];

    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [15:0]         r_conflict_cnt;
    logic                r_bus_rvalid, r_bus_err, r_bus_rd;
    logic                r_acc_rvalid, r_acc_rd;
    logic [BSEL_W-1:0]   r_bus_bank, r_acc_bank;

    generate
        if (BANK_BITS > 0) begin : g_bank_sel
            assign w_bus_bank = bus.addr[BANK_BITS-1:0];
            assign w_acc_bank = acc.addr[BANK_BITS-1:0];
        end else begin : g_single_bank
            assign w_bus_bank = '0;
            assign w_acc_bank = '0;
        end
    endgenerate

    assign w_bus_row  = bus.addr[ADDR_WIDTH-1:BANK_BITS];
    assign w_acc_row  = acc.addr[ADDR_WIDTH-1:BANK_BITS];
    assign w_wait_exp = (MAX_WAIT != 0) && (r_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_conflict = !rst && bus.req && acc.req && !i_lock && (w_bus_bank == w_acc_bank);

    // A locked bus never reaches a bank, so it cannot collide with the accelerator.
    always_comb begin
        w_bus_hit = '0;
        w_acc_hit = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bus_hit[b] = !rst && bus.req && !i_lock && (w_bus_bank == BSEL_W'(b));
            w_acc_hit[b] = !rst && acc.req && (w_acc_bank == BSEL_W'(b));
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            accel_bank_arb u_arb (
                .clk        (clk),
                .rst        (rst),
                .i_bus_hit  (w_bus_hit[b]),
                .i_acc_hit  (w_acc_hit[b]),
                .i_mode     (i_mode),
                .i_wait_exp (w_wait_exp),
                .o_bus_win  (w_bus_win[b]),
                .o_acc_win  (w_acc_win[b])
            );
            assign w_ram_rdata[b] = i_ram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign bus.gnt = !rst && bus.req && (i_lock || (|w_bus_win));
    assign acc.gnt = |w_acc_win;

    always_comb begin
        o_ram_en    = '0;
        o_ram_we    = '0;
        o_ram_addr  = '0;
        o_ram_be    = '0;
        o_ram_wdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bus_win[b]) begin
                o_ram_en[b]                            = 1'b1;
                o_ram_we[b]                            = bus.we;
                o_ram_addr[b*BANK_AW +: BANK_AW]       = w_bus_row;
                o_ram_be[b*BE_W +: BE_W]               = bus.be;
                o_ram_wdata[b*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
            end else if (w_acc_win[b]) begin
                o_ram_en[b]                            = 1'b1;
                o_ram_we[b]                            = acc.we;
                o_ram_addr[b*BANK_AW +: BANK_AW]       = w_acc_row;
                o_ram_be[b*BE_W +: BE_W]               = acc.be;
                o_ram_wdata[b*DATA_WIDTH +: DATA_WIDTH] = acc.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_lock || !bus.req || bus.gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_conf_clr) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_rvalid <= 1'b0;
            r_bus_err    <= 1'b0;
            r_bus_rd     <= 1'b0;
            r_bus_bank   <= '0;
            r_acc_rvalid <= 1'b0;
            r_acc_rd     <= 1'b0;
            r_acc_bank   <= '0;
        end else begin
            r_bus_rvalid <= bus.gnt;
            r_bus_err    <= bus.gnt && i_lock;
            r_bus_rd     <= bus.gnt && !i_lock && !bus.we;
            r_bus_bank   <= w_bus_bank;
            r_acc_rvalid <= acc.gnt;
            r_acc_rd     <= acc.gnt && !acc.we;
            r_acc_bank   <= w_acc_bank;
        end
    end

    // Responses are masked while rst is high so a grant just before reset never shows up.
    assign bus.rvalid = r_bus_rvalid && !rst;
    assign bus.err    = r_bus_err && !rst;
    assign bus.rdata  = (r_bus_rd && !rst) ? w_ram_rdata[r_bus_bank] : '0;
    assign acc.rvalid = r_acc_rvalid && !rst;
    assign acc.err    = 1'b0;
    assign acc.rdata  = (r_acc_rd && !rst) ? w_ram_rdata[r_acc_bank] : '0;

    assign o_conflict_cnt = r_conflict_cnt;
endmodule
